// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks register-file addresses and streams (address, data) words over valid/ready
module regfile_dump_reader #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int SKIP_ZERO  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] readRegister,
   input  logic [DATA_WIDTH-1:0] readData,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  done
);
   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} stateT;
   localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(SKIP_ZERO != 0 ? 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
   stateT state, stateNext;
   logic [ADDR_WIDTH-1:0] idx, outAddr;
   logic [DATA_WIDTH-1:0] outData;
   assign readRegister = idx;
   assign out_valid    = state == SEND;
   assign out_addr     = outAddr;
   assign out_data     = outData;
   assign busy         = state == READ || state == SEND;
   assign done         = state == DONE;
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= stateNext;
   // next state: abort beats both start and a simultaneous handshake
   always_comb begin
      stateNext = IDLE;
      case (state)
         IDLE: stateNext = (start && !abort) ? READ : IDLE;
         READ: stateNext = abort ? IDLE : SEND;
         SEND: stateNext = abort ? IDLE : !out_ready ? SEND : (idx == LAST_IDX) ? DONE : READ;
         default: stateNext = IDLE;
      endcase
   end
   // scan index and the sampled word, captured once per register at the READ edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         idx     <= '0;
         outAddr <= '0;
         outData <= '0;
      end else begin
         if (state == IDLE && stateNext == READ) idx <= FIRST_IDX;
         if (state == SEND && stateNext == READ) idx <= idx + 1'b1;
         if (state == READ && stateNext == SEND) begin
            outAddr <= idx;
            outData <= readData;
         end
      end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed table-driven checks of the register dump reader
module tb_regfile_dump_reader;
   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      int          stall;
      logic        wr;
      logic [4:0]  wa;
      logic [31:0] wd;
   } vecT;
   logic clk = 0, rst_n = 1, start = 0, abort = 0, out_ready = 1, sel = 0;
   logic [31:0] rf [32];
   logic [4:0] rr0, rr1, oa0, oa1, curRr, curAddr;
   logic [31:0] rd0, rd1, od0, od1, curData;
   logic ov0, ov1, b0, b1, d0, d1, curValid, curBusy, curDone;
   vecT tbl [$];
   int nCmp = 0, nErr = 0;
   always #5 clk = ~clk;
   assign rd0 = rf[rr0];
   assign rd1 = rf[rr1];
   assign curRr    = sel ? rr1 : rr0;
   assign curAddr  = sel ? oa1 : oa0;
   assign curData  = sel ? od1 : od0;
   assign curValid = sel ? ov1 : ov0;
   assign curBusy  = sel ? b1 : b0;
   assign curDone  = sel ? d1 : d0;
   regfile_dump_reader u0 (
      .clk(clk), .rst_n(rst_n), .start(start && !sel), .abort(abort),
      .readRegister(rr0), .readData(rd0), .out_valid(ov0), .out_ready(out_ready),
      .out_addr(oa0), .out_data(od0), .busy(b0), .done(d0)
   );
   regfile_dump_reader #(.NUM_REGS(4), .SKIP_ZERO(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start && sel), .abort(abort),
      .readRegister(rr1), .readData(rd1), .out_valid(ov1), .out_ready(out_ready),
      .out_addr(oa1), .out_data(od1), .busy(b1), .done(d1)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic preload();
      for (int i = 0; i < 32; i++) rf[i] = 0;
      rf[1] = 123;
      rf[2] = 456;
      rf[3] = 789;
   endtask
   task automatic addVec(input int a, input int d, input int stall, input logic wr, input int wa, input int wd);
      tbl.push_back('{addr: 5'(a), data: 32'(d), stall: stall, wr: wr, wa: 5'(wa), wd: 32'(wd)});
   endtask
   task automatic fillPlain();
      tbl.delete();
      for (int a = 0; a < 32; a++) addVec(a, a == 1 ? 123 : a == 2 ? 456 : a == 3 ? 789 : 0, 0, 0, 0, 0);
   endtask
   // entered at the negedge of a READ cycle; returns at the negedge after the last handshake
   task automatic runScan(input int n);
      for (int i = 0; i < n; i++) begin
         if (tbl[i].wr) rf[tbl[i].wa] = tbl[i].wd;
         chk($sformatf("readRegister[%0d]", i), 64'(curRr), 64'(tbl[i].addr));
         chk($sformatf("busyRead[%0d]", i), 64'(curBusy), 64'(1));
         chk($sformatf("validRead[%0d]", i), 64'(curValid), 64'(0));
         out_ready = tbl[i].stall == 0;
         @(negedge clk);
         chk($sformatf("valid[%0d]", i), 64'(curValid), 64'(1));
         chk($sformatf("addr[%0d]", i), 64'(curAddr), 64'(tbl[i].addr));
         chk($sformatf("data[%0d]", i), 64'(curData), 64'(tbl[i].data));
         for (int s = 0; s < tbl[i].stall; s++) begin
            @(negedge clk);
            chk($sformatf("stallValid[%0d.%0d]", i, s), 64'(curValid), 64'(1));
            chk($sformatf("stallAddr[%0d.%0d]", i, s), 64'(curAddr), 64'(tbl[i].addr));
            chk($sformatf("stallData[%0d.%0d]", i, s), 64'(curData), 64'(tbl[i].data));
         end
         out_ready = 1;
         @(negedge clk);
      end
   endtask
   task automatic chkDoneEnd(input string tag);
      chk({tag, "DonePulse"}, 64'(curDone), 64'(1));
      chk({tag, "DoneBusy"}, 64'(curBusy), 64'(0));
      chk({tag, "DoneValid"}, 64'(curValid), 64'(0));
      start = 0;
      @(negedge clk);
      chk({tag, "DoneOnce"}, 64'(curDone), 64'(0));
      @(negedge clk);
      chk({tag, "IdleBusy"}, 64'(curBusy), 64'(0));
      chk({tag, "IdleDone"}, 64'(curDone), 64'(0));
   endtask
   initial begin
      preload();
      #2 rst_n = 0;
      #1;
      chk("rstValid", 64'(ov0), 64'(0));
      chk("rstAddr", 64'(oa0), 64'(0));
      chk("rstData", 64'(od0), 64'(0));
      chk("rstReadRegister", 64'(rr0), 64'(0));
      chk("rstBusy", 64'(b0), 64'(0));
      chk("rstDone", 64'(d0), 64'(0));
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      // full scan with start held high throughout
      fillPlain();
      start = 1;
      @(negedge clk);
      runScan(32);
      chkDoneEnd("scanA");
      // backpressure on word 2 plus writes mid-scan
      tbl.delete();
      for (int a = 0; a < 32; a++)
         addVec(a, a == 1 ? 123 : a == 2 ? 456 : a == 3 ? 789 : a == 5 ? 555 : 0,
                a == 2 ? 5 : 0, a == 2 || a == 3, a == 2 ? 5 : 1, a == 2 ? 555 : 999);
      start = 1;
      @(negedge clk);
      start = 0;
      runScan(32);
      chkDoneEnd("scanB");
      // abort in SEND at idx 3, with a simultaneous handshake
      preload();
      fillPlain();
      start = 1;
      @(negedge clk);
      start = 0;
      runScan(3);
      @(negedge clk);
      chk("abortPreValid", 64'(curValid), 64'(1));
      chk("abortPreAddr", 64'(curAddr), 64'(3));
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("abortValid", 64'(curValid), 64'(0));
      chk("abortBusy", 64'(curBusy), 64'(0));
      chk("abortDone", 64'(curDone), 64'(0));
      chk("abortReadRegisterHold", 64'(curRr), 64'(3));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("abortNoDone[%0d]", c), 64'(curDone), 64'(0));
      end
      // start with abort in IDLE must not begin a scan
      start = 1;
      abort = 1;
      @(negedge clk);
      start = 0;
      abort = 0;
      chk("startAbortIdle", 64'(curBusy), 64'(0));
      // rescan from 0, then reset mid-SEND at idx 7
      start = 1;
      @(negedge clk);
      start = 0;
      runScan(7);
      @(negedge clk);
      chk("preResetValid", 64'(curValid), 64'(1));
      chk("preResetAddr", 64'(curAddr), 64'(7));
      rst_n = 0;
      #1;
      chk("midRstValid", 64'(ov0), 64'(0));
      chk("midRstAddr", 64'(oa0), 64'(0));
      chk("midRstData", 64'(od0), 64'(0));
      chk("midRstReadRegister", 64'(rr0), 64'(0));
      chk("midRstBusy", 64'(b0), 64'(0));
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("postRstBusy", 64'(b0), 64'(0));
      // SKIP_ZERO=1, NUM_REGS=4 instance
      sel = 1;
      tbl.delete();
      addVec(1, 123, 0, 0, 0, 0);
      addVec(2, 456, 0, 0, 0, 0);
      addVec(3, 789, 0, 0, 0, 0);
      start = 1;
      @(negedge clk);
      start = 0;
      runScan(3);
      chkDoneEnd("skipZero");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule
